key_debounce: RTL and testbench

- Front end of the key path. Takes four raw, bouncing, active-low push-button inputs and synchronises them to sys_clk.
- Debounces the key pattern as a whole and issues a one-cycle keyflag pulse with the stable keyvalue code on each qualified press.
- Optional auto-repeat for a held key.
- Drives the keyvalue/keyflag pair consumed by the key-state logic, which acts on codes 4'b1110, 4'b1101, 4'b1011 and 4'b0111.

---
 rtl/key_pkg.sv | 18 +
 rtl/key_sync.sv | 27 ++
 rtl/key_debounce.sv | 127 ++++++++++++
 tb/tb_key_debounce.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared key-path definitions: debounce FSM states and the active-low key codes
// understood by both this front end and the key-state consumer.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } key_state_e;

   localparam logic [3:0] KEY_NONE = 4'b1111;
   localparam logic [3:0] KEY0     = 4'b1110;
   localparam logic [3:0] KEY1     = 4'b1101;
   localparam logic [3:0] KEY2     = 4'b1011;
   localparam logic [3:0] KEY3     = 4'b0111;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for asynchronous active-low inputs; two cycles of latency.
// No flow control; resets to all-ones so an idle (released) input is assumed.
module key_sync #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] s1_q;
   logic [W-1:0] s2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= '1;
         s2_q <= '1;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces the 4-bit key pattern as a whole; one-cycle keyflag per press (plus optional auto-repeat).
// Latency DB_CYCLES+3 edges from first sample to keyflag; no backpressure, consumer must take every pulse.
module key_debounce
   import key_pkg::*;
#(
   parameter int DB_CYCLES        = 1_000_000,
   parameter int REPEAT_EN        = 0,
   parameter int RPT_DELAY_CYCLES = 25_000_000,
   parameter int RPT_RATE_CYCLES  = 5_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [3:0] key,
   output logic [3:0] keyvalue,
   output logic       keyflag,
   output logic       key_held
);

   localparam int CNT_W = $clog2(DB_CYCLES);
   localparam int RPT_W = (RPT_DELAY_CYCLES > 1) ? $clog2(RPT_DELAY_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DB_CYCLES - 1);
   localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(RPT_DELAY_CYCLES - 1);
   // Reloading to DELAY-RATE makes the next terminal count land RATE cycles later.
   localparam logic [RPT_W-1:0] RPT_RELOAD = (RPT_RATE_CYCLES >= RPT_DELAY_CYCLES) ? '0 :
                                             RPT_W'(RPT_DELAY_CYCLES - RPT_RATE_CYCLES);

   logic [3:0]       key_s;
   key_state_e       state_q, state_d;
   logic [3:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic [3:0]       keyvalue_q, keyvalue_d;
   logic             keyflag_q, keyflag_d;

   key_sync #(.W(4)) u_key_sync (
      .clk_i  (sys_clk),
      .rst_ni (sys_rst_n),
      .d_i    (key),
      .q_o    (key_s)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         cand_q     <= KEY_NONE;
         cnt_q      <= '0;
         rpt_q      <= '0;
         keyvalue_q <= KEY_NONE;
         keyflag_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         rpt_q      <= rpt_d;
         keyvalue_q <= keyvalue_d;
         keyflag_q  <= keyflag_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cand_d     = cand_q;
      cnt_d      = cnt_q;
      rpt_d      = rpt_q;
      keyvalue_d = keyvalue_q;
      keyflag_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (key_s != KEY_NONE) begin
               state_d = PRESS_DB;
               cand_d  = key_s;
               cnt_d   = '0;
            end
         end
         PRESS_DB: begin
            if (key_s == KEY_NONE) begin
               state_d = IDLE;
            end else if (key_s != cand_q) begin
               cand_d = key_s;
               cnt_d  = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d    = HELD;
               keyvalue_d = cand_q;
               keyflag_d  = 1'b1;
               rpt_d      = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            if (key_s != keyvalue_q) begin
               state_d = RELEASE_DB;
               cnt_d   = '0;
            end else if (REPEAT_EN != 0) begin
               if (rpt_q == RPT_LAST) begin
                  keyflag_d = 1'b1;
                  rpt_d     = RPT_RELOAD;
               end else begin
                  rpt_d = rpt_q + 1'b1;
               end
            end
         end
         RELEASE_DB: begin
            // rpt is left alone so a release glitch does not restart the repeat schedule
            if (key_s == keyvalue_q) begin
               state_d = HELD;
            end else if (key_s == KEY_NONE) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      keyvalue = keyvalue_q;
      keyflag  = keyflag_q;
      key_held = (state_q == HELD) || (state_q == RELEASE_DB);
   end

endmodule

// File: tb/tb_key_debounce.sv
// Randomized and directed bench for key_debounce; two instances (repeat off / on) share one key stimulus.
module tb_key_debounce;

   localparam int DB   = 8;
   localparam int DLY  = 40;
   localparam int RATE = 10;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] key   = 4'hF;
   logic [3:0] kv0, kv1;
   logic       f0, f1, h0, h1;

   always #5 clk = ~clk;

   key_debounce #(.DB_CYCLES(DB), .REPEAT_EN(0), .RPT_DELAY_CYCLES(DLY), .RPT_RATE_CYCLES(RATE)) u_dut0 (
      .sys_clk(clk), .sys_rst_n(rst_n), .key(key), .keyvalue(kv0), .keyflag(f0), .key_held(h0));
   key_debounce #(.DB_CYCLES(DB), .REPEAT_EN(1), .RPT_DELAY_CYCLES(DLY), .RPT_RATE_CYCLES(RATE)) u_dut1 (
      .sys_clk(clk), .sys_rst_n(rst_n), .key(key), .keyvalue(kv1), .keyflag(f1), .key_held(h1));

   int total = 0;
   int bad   = 0;
   int cycle = 0;
   int pulses[2];
   int lastp[2];
   bit prevf[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d obs=%0h exp=%0h", tag, cycle, obs, exp);
      end
   endtask

   // Reference model: works on run lengths of the synchronised pattern rather than a state encoding.
   logic [3:0] hist[$];
   logic [3:0] m_kv[2];
   logic [3:0] m_last[2];
   bit         m_flag[2], m_lat[2], m_rel[2];
   int         m_run[2], m_ones[2], m_ht[2];

   function automatic void m_reset();
      hist = '{4'hF, 4'hF};
      for (int i = 0; i < 2; i++) begin
         m_kv[i] = 4'hF; m_last[i] = 4'hF; m_flag[i] = 0; m_lat[i] = 0; m_rel[i] = 0;
         m_run[i] = 0; m_ones[i] = 0; m_ht[i] = 0;
      end
   endfunction

   function automatic void m_step(input logic [3:0] k);
      logic [3:0] ks;
      hist.push_back(k);
      ks = hist.pop_front();
      for (int i = 0; i < 2; i++) begin
         m_flag[i] = 0;
         if (!m_lat[i]) begin
            if (ks == 4'hF)          m_run[i] = 0;
            else if (ks == m_last[i]) m_run[i]++;
            else                      m_run[i] = 1;
            m_last[i] = ks;
            if (m_run[i] == DB + 1) begin
               m_lat[i] = 1; m_rel[i] = 0; m_kv[i] = ks; m_flag[i] = 1; m_ht[i] = 0;
            end
         end else if (!m_rel[i]) begin
            if (ks != m_kv[i]) begin
               m_rel[i] = 1; m_ones[i] = 0;
            end else if (i == 1) begin
               m_ht[i]++;
               if (m_ht[i] >= DLY && ((m_ht[i] - DLY) % RATE) == 0) m_flag[i] = 1;
            end
         end else begin
            if (ks == m_kv[i]) m_rel[i] = 0;
            else if (ks == 4'hF) begin
               m_ones[i]++;
               if (m_ones[i] == DB) begin
                  m_lat[i] = 0; m_last[i] = 4'hF; m_run[i] = 0;
               end
            end else m_ones[i] = 0;
         end
      end
   endfunction

   initial m_reset();

   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (rst_n) m_step(key);
   end

   always @(negedge clk) begin
      if (!rst_n) m_reset();
      chk("flag0", f0, m_flag[0]);
      chk("kv0",   kv0, m_kv[0]);
      chk("held0", h0, m_lat[0]);
      chk("flag1", f1, m_flag[1]);
      chk("kv1",   kv1, m_kv[1]);
      chk("held1", h1, m_lat[1]);
      chk("dbl0",  f0 & prevf[0], 0);
      chk("dbl1",  f1 & prevf[1], 0);
      prevf[0] = f0;
      prevf[1] = f1;
      if (f0) begin pulses[0]++; lastp[0] = cycle; end
      if (f1) begin pulses[1]++; lastp[1] = cycle; end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic release_all();
      key = 4'hF;
      cyc(20);
   endtask

   initial begin
      int c;
      int p0, p1;
      logic [3:0] codes[4];
      codes = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

      cyc(3);
      chk("rst_kv", kv0, 4'hF);
      rst_n = 1'b1;
      cyc(3);

      // clean press
      p0 = pulses[0]; key = 4'b1011; c = cycle;
      cyc(30);
      chk("t1_cnt", pulses[0] - p0, 1);
      chk("t1_lat", lastp[0] - c, 11);
      chk("t1_kv",  kv0, 4'b1011);
      chk("t1_held", h0, 1);
      release_all();

      // bounce then settle
      p0 = pulses[0];
      for (int i = 0; i < 5; i++) begin
         key = 4'b1110; cyc(3);
         key = 4'b1111; cyc(3);
      end
      chk("t2_nobounce", pulses[0] - p0, 0);
      key = 4'b1110; c = cycle;
      cyc(30);
      chk("t2_cnt", pulses[0] - p0, 1);
      chk("t2_lat", lastp[0] - c, 11);
      chk("t2_kv",  kv0, 4'b1110);
      release_all();

      // release glitch
      key = 4'b1101;
      cyc(20);
      p0 = pulses[0];
      key = 4'hF;    cyc(4);
      key = 4'b1101; cyc(5);
      chk("t3_held_glitch", h0, 1);
      key = 4'hF;    cyc(12);
      chk("t3_held_off", h0, 0);
      chk("t3_kv", kv0, 4'b1101);
      chk("t3_cnt", pulses[0] - p0, 0);
      release_all();

      // auto-repeat
      p0 = pulses[0]; p1 = pulses[1];
      key = 4'b0111;
      cyc(105);
      chk("t4_cnt0", pulses[0] - p0, 1);
      chk("t4_cnt1", pulses[1] - p1, 7);
      chk("t4_kv1",  kv1, 4'b0111);
      release_all();

      // reset mid-debounce
      p0 = pulses[0];
      key = 4'b1110;
      cyc(6);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_kv",   kv0, 4'hF);
      chk("t5_rst_flag", f0, 0);
      chk("t5_rst_held", h0, 0);
      cyc(2);
      rst_n = 1'b1; c = cycle;
      cyc(30);
      chk("t5_cnt", pulses[0] - p0, 1);
      chk("t5_lat", lastp[0] - c, 11);
      release_all();

      // chord change during debounce
      p0 = pulses[0];
      key = 4'b1110;
      cyc(5);
      key = 4'b1100; c = cycle;
      cyc(30);
      chk("t6_cnt", pulses[0] - p0, 1);
      chk("t6_lat", lastp[0] - c, 11);
      chk("t6_kv",  kv0, 4'b1100);
      release_all();

      // random patterns, durations and occasional resets
      for (int n = 0; n < 150; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 3)      key = 4'hF;
         else if (r < 7) key = codes[$urandom_range(0, 3)];
         else            key = 4'($urandom);
         if ($urandom_range(0, 9) == 0) cyc(60);
         else                           cyc($urandom_range(1, 25));
         if ($urandom_range(0, 40) == 0) begin
            rst_n = 1'b0; cyc(2); rst_n = 1'b1;
         end
      end
      release_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
